// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: memory-mapped GPIO peripheral for the core data bus.
// Drives gpio_port_out from a software register, synchronizes gpio_port_in,
// records rising edges in a sticky W1C register and raises a level irq.
// Optional per-bit input debounce is compiled in with `define GPIO_DEBOUNCE_EN.
module gpio_port_ctrl #(
  parameter int                  GPIO_WIDTH      = 8,
  parameter int                  DATA_WIDTH      = 32,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET     = '0,
  parameter int                  DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_we,
  input  logic                  bus_re,
  input  logic [3:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_rvalid,
  input  logic [GPIO_WIDTH-1:0] gpio_port_in,
  output logic [GPIO_WIDTH-1:0] gpio_port_out,
  output logic                  irq
);

  typedef enum logic [1:0] {
    REG_OUT    = 2'd0,
    REG_IN     = 2'd1,
    REG_EDGE   = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_sel_t;

  reg_sel_t              sel;
  logic [GPIO_WIDTH-1:0] sync1_q;
  logic [GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] filt;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] edge_q;
  logic [GPIO_WIDTH-1:0] irq_en_q;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_bits;

  assign sel         = reg_sel_t'(bus_addr[3:2]);
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[DATA_WIDTH-1:GPIO_WIDTH]};

  // Two-flop synchronizer on the asynchronous pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= gpio_port_in;
      sync_q  <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [7:0]            cnt_q [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] filt_q;

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
        if (sync_q[i] != filt_q[i]) begin
          if (cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
            filt_q[i] <= sync_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 8'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q;
`endif

  // prev_q doubles as the IN register, so IN and EDGE become visible on the same edge.
  assign rise     = filt & ~prev_q;
  assign w1c_mask = (bus_we && sel == REG_EDGE) ? bus_wdata[GPIO_WIDTH-1:0] : '0;

  // Software registers, sticky edge flags (set beats clear) and registered irq.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_port_out <= OUT_RESET;
      irq_en_q      <= '0;
      edge_q        <= '0;
      prev_q        <= '0;
      irq           <= 1'b0;
    end else begin
      prev_q <= filt;
      edge_q <= (edge_q & ~w1c_mask) | rise;
      irq    <= |(edge_q & irq_en_q);
      if (bus_we && sel == REG_OUT)    gpio_port_out <= bus_wdata[GPIO_WIDTH-1:0];
      if (bus_we && sel == REG_IRQ_EN) irq_en_q      <= bus_wdata[GPIO_WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_OUT:    rd_val[GPIO_WIDTH-1:0] = gpio_port_out;
      REG_IN:     rd_val[GPIO_WIDTH-1:0] = prev_q;
      REG_EDGE:   rd_val[GPIO_WIDTH-1:0] = edge_q;
      REG_IRQ_EN: rd_val[GPIO_WIDTH-1:0] = irq_en_q;
      default:    rd_val = '0;
    endcase
  end

  // Registered read port; rdata holds until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re) bus_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl: directed self-checking bench for gpio_port_ctrl.
module tb_gpio_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_we, bus_re;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [7:0]  gpio_port_in;
  logic [7:0]  gpio_port_out;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  gpio_port_ctrl #(
    .GPIO_WIDTH(8),
    .DATA_WIDTH(32),
    .OUT_RESET(8'h00),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_we(bus_we),
    .bus_re(bus_re),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid),
    .gpio_port_in(gpio_port_in),
    .gpio_port_out(gpio_port_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [3:0] a, input logic [31:0] w);
    @(negedge clk);
    bus_addr = a; bus_wdata = w; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
    v = bus_rvalid;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0; gpio_port_in = '0;
    #1;
    tests_run++;
    if (gpio_port_out !== 8'h00 || irq !== 1'b0 || bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got out=%h irq=%b rvalid=%b rdata=%h expected 00 0 0 0",
               gpio_port_out, irq, bus_rvalid, bus_rdata);
    end
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    bus_addr = 4'h0; bus_re = 1'b1;
    tests_run++;
    if (bus_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rvalid_early: got %b expected 0", bus_rvalid);
    end
    @(negedge clk);
    bus_re = 1'b0;
    tests_run++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL read_out_reset: got rvalid=%b rdata=%h expected 1 00000000", bus_rvalid, bus_rdata);
    end
    @(negedge clk);
    tests_run++;
    if (bus_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rvalid_one_cycle: got %b expected 0", bus_rvalid);
    end
    do_read(4'hC, d, v);
    tests_run++;
    if (v !== 1'b1 || d !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_irq_en_reset: got rvalid=%b rdata=%h irq=%b expected 1 00000000 0", v, d, irq);
    end
  endtask

  task automatic test_out_write();
    logic [31:0] d; logic v;
    @(negedge clk);
    bus_addr = 4'h0; bus_wdata = 32'hFFFF_FFA5; bus_we = 1'b1;
    tests_run++;
    if (gpio_port_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL out_before_write: got %h expected 00", gpio_port_out);
    end
    @(negedge clk);
    bus_we = 1'b0;
    tests_run++;
    if (gpio_port_out !== 8'hA5) begin
      tests_failed++;
      $display("FAIL out_after_write: got %h expected a5", gpio_port_out);
    end
    do_read(4'h1, d, v);
    tests_run++;
    if (v !== 1'b1 || d !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL read_out: got rvalid=%b rdata=%h expected 1 000000a5", v, d);
    end
  endtask

  task automatic test_input_edge();
    logic [31:0] d; logic v;
    @(negedge clk);
    gpio_port_in = 8'b0000_0110;
    wait_cycles(5);
    do_read(4'h4, d, v);
    tests_run++;
    if (d !== 32'h06) begin
      tests_failed++;
      $display("FAIL read_in: got %h expected 00000006", d);
    end
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h06) begin
      tests_failed++;
      $display("FAIL read_edge: got %h expected 00000006", d);
    end
    do_write(4'hC, 32'h02);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_latency: got %b expected 0", irq);
    end
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d; logic v;
    do_write(4'h8, 32'h02);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_hold_after_w1c: got %b expected 1", irq);
    end
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_drop: got %b expected 0", irq);
    end
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h04) begin
      tests_failed++;
      $display("FAIL edge_after_w1c: got %h expected 00000004", d);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d; logic v;
    @(negedge clk);
    gpio_port_in = 8'h04;
    wait_cycles(5);
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h04) begin
      tests_failed++;
      $display("FAIL falling_ignored: got %h expected 00000004", d);
    end
    @(negedge clk);
    gpio_port_in = 8'h06;
    @(negedge clk);
    @(negedge clk);
    bus_addr = 4'h8; bus_wdata = 32'h02; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h06) begin
      tests_failed++;
      $display("FAIL set_beats_clear: got %h expected 00000006", d);
    end
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_after_collision: got %b expected 1", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    @(negedge clk);
    bus_addr = 4'h0; bus_wdata = 32'h3C; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    tests_run++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 32'hA5 || gpio_port_out !== 8'h3C) begin
      tests_failed++;
      $display("FAIL we_re_same_cycle: got rvalid=%b rdata=%h out=%h expected 1 000000a5 3c",
               bus_rvalid, bus_rdata, gpio_port_out);
    end
    do_write(4'h4, 32'hFF);
    do_read(4'h4, d, v);
    tests_run++;
    if (d !== 32'h06) begin
      tests_failed++;
      $display("FAIL in_write_ignored: got %h expected 00000006", d);
    end
    do_read(4'h0, d, v);
    tests_run++;
    if (d !== 32'h3C) begin
      tests_failed++;
      $display("FAIL read_out_b2b: got %h expected 0000003c", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v;
    @(negedge clk);
    gpio_port_in = 8'h00;
    wait_cycles(5);
    @(negedge clk);
    bus_addr = 4'h0; bus_re = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rvalid_before_reset: got %b expected 1", bus_rvalid);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (bus_rvalid !== 1'b0 || gpio_port_out !== 8'h00 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got rvalid=%b out=%h irq=%b expected 0 00 0", bus_rvalid, gpio_port_out, irq);
    end
    @(negedge clk);
    tests_run++;
    if (bus_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rvalid_dropped: got %b expected 0", bus_rvalid);
    end
    bus_re = 1'b0;
    rst = 1'b1;
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL edge_after_reset: got %h expected 00000000", d);
    end
    do_read(4'hC, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL irq_en_after_reset: got %h expected 00000000", d);
    end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d; logic v;
    @(negedge clk);
    gpio_port_in = 8'h01;
    wait_cycles(3);
    gpio_port_in = 8'h00;
    wait_cycles(10);
    do_read(4'h4, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL debounce_short_in: got %h expected 00000000", d);
    end
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL debounce_short_edge: got %h expected 00000000", d);
    end
    @(negedge clk);
    gpio_port_in = 8'h01;
    wait_cycles(8);
    do_read(4'h4, d, v);
    tests_run++;
    if (d !== 32'h01) begin
      tests_failed++;
      $display("FAIL debounce_long_in: got %h expected 00000001", d);
    end
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h01) begin
      tests_failed++;
      $display("FAIL debounce_long_edge: got %h expected 00000001", d);
    end
  endtask
`else
  task automatic test_glitch();
    logic [31:0] d; logic v;
    @(negedge clk);
    gpio_port_in = 8'h01;
    @(negedge clk);
    gpio_port_in = 8'h00;
    wait_cycles(5);
    do_read(4'h8, d, v);
    tests_run++;
    if (d !== 32'h01) begin
      tests_failed++;
      $display("FAIL glitch_edge: got %h expected 00000001", d);
    end
    do_read(4'h4, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL glitch_in: got %h expected 00000000", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_out_write();
    test_input_edge();
    test_w1c();
    test_w1c_collision();
    test_back_to_back();
    test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`else
    test_glitch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
